// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel button/switch conditioner. Each channel owns a 2-flop
// synchroniser, a debounce counter, a debounced level, one-cycle press /
// release pulses and a hold counter that produces a single long-press pulse
// per press. An optional shared tick slows every counter (but never the
// synchroniser), so long hold times fit in narrow counters.
//
// Parameters:
//   NUM_CH      number of independent channels
//   CNT_WIDTH   width of each debounce counter
//   DB_TICKS    ticks a new level must persist before it is accepted
//               (1 .. 2**CNT_WIDTH)
//   LONG_WIDTH  width of each hold counter
//   LONG_TICKS  ticks after a press at which long_press fires
//               (1 .. 2**LONG_WIDTH-1)
//   ACTIVE_LOW  1: raw inputs are inverted before synchronisation, so
//               "pressed" is always 1 internally and on the outputs
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   tick        counter enable (tie high for per-clock counting)
//   noisy_btn   raw asynchronous inputs, one bit per channel
//   clean_btn   debounced logical level (1 = pressed)
//   press       one-cycle pulse on a clean 0->1 transition
//   released    one-cycle pulse on a clean 1->0 transition
//   long_press  one-cycle pulse once per press after LONG_TICKS held ticks
//
// All outputs are registered. press and released are set on the same edge
// that updates clean_btn, so they are high exactly in the first cycle the
// new clean level is visible.
// -----------------------------------------------------------------------------
module debounce_multi #(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int DB_TICKS   = 50000,
  parameter int LONG_WIDTH = 8,
  parameter int LONG_TICKS = 200,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [NUM_CH-1:0] noisy_btn,
  output logic [NUM_CH-1:0] clean_btn,
  output logic [NUM_CH-1:0] press,
  output logic [NUM_CH-1:0] released,
  output logic [NUM_CH-1:0] long_press
);

  // Terminal debounce count. DB_TICKS may equal 2**CNT_WIDTH, in which case
  // the terminal value is all ones and the counter still never wraps.
  localparam logic [CNT_WIDTH-1:0]  DB_LAST  = CNT_WIDTH'(DB_TICKS - 1);
  localparam logic [LONG_WIDTH-1:0] LONG_MAX = LONG_WIDTH'(LONG_TICKS);
  localparam logic                  INV      = (ACTIVE_LOW != 0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                  sync1;
    logic                  sync2;
    logic                  clean;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [LONG_WIDTH-1:0] hold;
    logic [LONG_WIDTH-1:0] hold_nxt;
    logic                  press_r;
    logic                  rel_r;
    logic                  long_r;
    logic                  qualified;
    logic                  rising;
    logic                  falling;
    logic                  raw_in;

    assign raw_in = noisy_btn[i] ^ INV;

    // The new level has persisted for DB_TICKS enabled ticks on this edge.
    assign qualified = (sync2 != clean) && tick && (cnt == DB_LAST);
    assign rising    = qualified &&  sync2;
    assign falling   = qualified && !sync2;

    // Hold counter: cleared while released and on the press edge itself,
    // then counts enabled ticks and saturates so long_press cannot repeat.
    always_comb begin
      hold_nxt = hold;
      if (!clean || rising) begin
        hold_nxt = '0;
      end else if (tick && (hold < LONG_MAX)) begin
        hold_nxt = hold + LONG_WIDTH'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // Synchroniser resets to logical 0 so an idle pin (either polarity)
        // produces no press at reset release.
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        clean   <= 1'b0;
        cnt     <= '0;
        hold    <= '0;
        press_r <= 1'b0;
        rel_r   <= 1'b0;
        long_r  <= 1'b0;
      end else begin
        sync1 <= raw_in;
        sync2 <= sync1;

        // Any return to the current clean level restarts qualification,
        // independent of tick.
        if (sync2 == clean) begin
          cnt <= '0;
        end else if (tick) begin
          if (cnt == DB_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end

        if (qualified) begin
          clean <= sync2;
        end

        press_r <= rising;
        rel_r   <= falling;
        hold    <= hold_nxt;
        // Fires only on the edge where hold reaches LONG_TICKS.
        long_r  <= (hold != LONG_MAX) && (hold_nxt == LONG_MAX);
      end
    end

    assign clean_btn[i]  = clean;
    assign press[i]      = press_r;
    assign released[i]   = rel_r;
    assign long_press[i] = long_r;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
//
// Directed bench for debounce_multi. Two instances share clock, reset and
// tick: dut_a (ACTIVE_LOW=0) and dut_b (ACTIVE_LOW=1), both with
// NUM_CH=2, CNT_WIDTH=4, DB_TICKS=4, LONG_WIDTH=4, LONG_TICKS=8.
//
// Inputs change at the falling edge; outputs are sampled at the falling edge.
// Edge index k counts rising edges since the last mark(); an input set just
// before cyc() is sampled on edge k = current index. For each output the
// bench records the edge index after which it was first seen high and how
// many cycles it was high; expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b1;
  logic [1:0] noisy_a = 2'b00;
  logic [1:0] noisy_b = 2'b11;

  logic [1:0] clean_a, press_a, rel_a, long_a;
  logic [1:0] clean_b, press_b, rel_b, long_b;

  int total = 0;
  int bad = 0;
  int ecount;
  // [dut][channel]: pulse counts and first-seen edge index (-1 = never)
  int pc[2][2], rc[2][2], lc[2][2], cc[2][2];
  int fp[2][2], fr[2][2], fl[2][2], fc[2][2];
  int both_seen;

  debounce_multi #(
    .NUM_CH(2), .CNT_WIDTH(4), .DB_TICKS(4),
    .LONG_WIDTH(4), .LONG_TICKS(8), .ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .noisy_btn(noisy_a),
    .clean_btn(clean_a), .press(press_a), .released(rel_a),
    .long_press(long_a)
  );

  debounce_multi #(
    .NUM_CH(2), .CNT_WIDTH(4), .DB_TICKS(4),
    .LONG_WIDTH(4), .LONG_TICKS(8), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .noisy_btn(noisy_b),
    .clean_btn(clean_b), .press(press_b), .released(rel_b),
    .long_press(long_b)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  task automatic mark();
    ecount = 0;
    both_seen = 0;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        pc[d][c] = 0; rc[d][c] = 0; lc[d][c] = 0; cc[d][c] = 0;
        fp[d][c] = -1; fr[d][c] = -1; fl[d][c] = -1; fc[d][c] = -1;
      end
    end
  endtask

  task automatic sample();
    logic p, r, l, k;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        p = (d == 0) ? press_a[c] : press_b[c];
        r = (d == 0) ? rel_a[c]   : rel_b[c];
        l = (d == 0) ? long_a[c]  : long_b[c];
        k = (d == 0) ? clean_a[c] : clean_b[c];
        if (p) begin pc[d][c]++; if (fp[d][c] < 0) fp[d][c] = ecount; end
        if (r) begin rc[d][c]++; if (fr[d][c] < 0) fr[d][c] = ecount; end
        if (l) begin lc[d][c]++; if (fl[d][c] < 0) fl[d][c] = ecount; end
        if (k) begin cc[d][c]++; if (fc[d][c] < 0) fc[d][c] = ecount; end
      end
    end
    if (press_a == 2'b11) both_seen++;
  endtask

  // ---------------------------------------------------------------- driver
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    sample();
    ecount++;
  endtask

  // Bounce stimulus indexed by sampling edge: 1,0,1,0 for 3 clocks each,
  // stable 1 from edge 12, then back to 0 from edge 19.
  function automatic logic bounce_lvl(input int k);
    if (k < 3)  return 1'b1;
    if (k < 6)  return 1'b0;
    if (k < 9)  return 1'b1;
    if (k < 12) return 1'b0;
    if (k < 19) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------------------------------------------------------- tests
  initial begin
    // Reset with idle inputs on both polarities.
    repeat (3) @(negedge clk);
    check("rst_clean_a", int'(clean_a), 0);
    check("rst_press_a", int'(press_a), 0);
    check("rst_rel_a",   int'(rel_a),   0);
    check("rst_long_a",  int'(long_a),  0);
    check("rst_clean_b", int'(clean_b), 0);
    check("rst_press_b", int'(press_b), 0);
    rst_n = 1'b1;
    mark();
    repeat (20) cyc();
    check("idle_a_clean", cc[0][0] + cc[0][1], 0);
    check("idle_a_pulse", pc[0][0] + pc[0][1] + rc[0][0] + rc[0][1]
                          + lc[0][0] + lc[0][1], 0);
    check("idle_b_clean", cc[1][0] + cc[1][1], 0);
    check("idle_b_pulse", pc[1][0] + pc[1][1] + rc[1][0] + rc[1][1]
                          + lc[1][0] + lc[1][1], 0);

    // Step ch0 of dut_a (and ch1 of dut_b, active low) and hold 30 edges.
    mark();
    noisy_a = 2'b01;
    noisy_b = 2'b01;
    repeat (30) cyc();
    check("step_clean_edge", fc[0][0], 5);
    check("step_press_edge", fp[0][0], 5);
    check("step_press_cnt",  pc[0][0], 1);
    check("step_ch1_quiet",  pc[0][1] + cc[0][1], 0);
    check("step_no_release", rc[0][0], 0);
    check("long_cnt",        lc[0][0], 1);
    check("long_edge",       fl[0][0], 13);
    check("step_clean_lvl",  int'(clean_a), 1);
    check("b_press_edge",    fp[1][1], 5);
    check("b_ch0_quiet",     pc[1][0] + cc[1][0], 0);

    // Release after long press.
    mark();
    noisy_a = 2'b00;
    noisy_b = 2'b11;
    repeat (8) cyc();
    check("rel_edge",     fr[0][0], 5);
    check("rel_cnt",      rc[0][0], 1);
    check("rel_no_press", pc[0][0] + lc[0][0], 0);
    check("b_rel_edge",   fr[1][1], 5);

    // Bounce, settle, then release before the long-press point.
    mark();
    for (int k = 0; k < 35; k++) begin
      noisy_a[0] = bounce_lvl(k);
      cyc();
    end
    check("bounce_clean_edge", fc[0][0], 17);
    check("bounce_press_cnt",  pc[0][0], 1);
    check("bounce_rel_edge",   fr[0][0], 24);
    check("bounce_rel_cnt",    rc[0][0], 1);
    check("short_no_long",     lc[0][0], 0);
    check("bounce_end_lvl",    int'(clean_a), 0);

    // Both channels together.
    mark();
    noisy_a = 2'b11;
    repeat (6) cyc();
    check("both_press0_edge", fp[0][0], 5);
    check("both_press1_edge", fp[0][1], 5);
    check("both_same_cycle",  both_seen, 1);
    mark();
    noisy_a = 2'b00;
    repeat (8) cyc();
    check("both_rel0", rc[0][0], 1);
    check("both_rel1", rc[0][1], 1);
    check("both_no_long", lc[0][0] + lc[0][1], 0);

    // tick asserted one clock in four.
    mark();
    noisy_a = 2'b01;
    for (int k = 0; k < 20; k++) begin
      tick = ((k % 4) == 3);
      cyc();
    end
    check("tick_clean_edge", fc[0][0], 15);
    check("tick_press_cnt",  pc[0][0], 1);
    check("tick_no_long",    lc[0][0], 0);
    tick = 1'b1;
    mark();
    noisy_a = 2'b00;
    repeat (8) cyc();
    check("tick_rel_cnt", rc[0][0], 1);

    // Reset mid-qualification.
    mark();
    noisy_a = 2'b01;
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    check("midrst_clean", int'(clean_a), 0);
    check("midrst_press", int'(press_a), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    ecount = 0;
    repeat (10) cyc();
    check("midrst_clean_edge", fc[0][0], 5);
    check("midrst_press_cnt",  pc[0][0], 1);
    check("midrst_no_other",   rc[0][0] + rc[0][1] + lc[0][0] + lc[0][1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Multi-channel, parametrised button/switch conditioner. Each channel has its own 2-flop synchroniser, debounce counter and debounced level.
- Generates one-cycle press and release pulses, plus a one-cycle long-press pulse.
- Optional input polarity inversion. An optional shared tick enable slows the counters so wide hold times do not need wide registers.
- Sits between board pins (buttons/switches) and control FSMs.

Parameters:
- NUM_CH, 4, number of independent channels.
- CNT_WIDTH, 16, width of each debounce counter.
- DB_TICKS, 50000, consecutive enabled ticks a new level must persist before it is accepted. Legal range 1..2^CNT_WIDTH.
- LONG_WIDTH, 8, width of each hold counter.
- LONG_TICKS, 200, enabled ticks after a press at which long_press fires. Legal range 1..2^LONG_WIDTH-1.
- ACTIVE_LOW, 0, if 1 the raw inputs are inverted before synchronisation, so logical "pressed" is always 1 internally and on outputs.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  counter enable. Tie to 1'b1 for per-clock counting. The synchroniser ignores it.
- noisy_btn  in  NUM_CH  raw asynchronous inputs, one bit per channel.
- clean_btn  out  NUM_CH  debounced logical level (1 = pressed).
- press  out  NUM_CH  one-cycle pulse on a clean 0->1 transition.
- release  out  NUM_CH  one-cycle pulse on a clean 1->0 transition.
- long_press  out  NUM_CH  one-cycle pulse once per press, after LONG_TICKS ticks held.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - clean_btn, press, release, long_press all 0.
  - Both synchroniser stages reset to logical 0, i.e. raw 1 when ACTIVE_LOW=1, so no spurious press at reset release.
  - All counters are 0.
- Synchroniser: per channel, in = noisy_btn[i] ^ ACTIVE_LOW. Two flops, sync1 then sync2, clocked every clk regardless of tick.
- Debounce counter, per channel, evaluated every clk edge:
  - sync2 == clean: cnt <= 0 (regardless of tick). Any bounce back restarts qualification.
  - sync2 != clean, tick=0: cnt holds.
  - sync2 != clean, tick=1, cnt == DB_TICKS-1: clean <= sync2 and cnt <= 0.
  - sync2 != clean, tick=1, otherwise: cnt <= cnt + 1.
- Latency with tick=1: raw input stable from sampling edge E0 gives sync2 valid after E1, and clean updates on edge E0+DB_TICKS+1.
- Edge pulses:
  - press[i] is registered and high exactly the one cycle in which clean[i] first reads 1. It is set on the same edge that sets clean.
  - release[i] is the same for 1->0.
  - The two are never simultaneous on one channel.
- Hold counter, per channel:
  - If clean is 0, or clean is rising on this edge: hold <= 0.
  - Else if tick=1 and hold < LONG_TICKS: hold <= hold + 1.
  - Saturates at LONG_TICKS. No wrap, so no repeat pulses.
  - long_press[i] is high the one cycle after the edge on which hold becomes LONG_TICKS.
  - With tick=1 this is exactly LONG_TICKS clocks after the press pulse.
  - A release before that point cancels it. A new press restarts the count from 0.
- Channels are fully independent. Simultaneous events on several channels all pulse in the same cycle.
- No counter ever wraps: the debounce counter is cleared at its terminal count, and the hold counter saturates.
- rst_n asserted mid-qualification or mid-hold: all state is cleared immediately. No pulse is emitted on reset entry or exit.
- tick held 0: clean, hold and pulses are frozen. The synchroniser keeps tracking.

Test Plan (NUM_CH=2, CNT_WIDTH=4, DB_TICKS=4, LONG_WIDTH=4, LONG_TICKS=8, ACTIVE_LOW=0, tick=1 unless stated):
- Reset release with noisy_btn=2'b00, then 20 clocks -> all outputs remain 0. Repeat with ACTIVE_LOW=1 and noisy_btn=2'b11 -> all outputs 0.
- ch0 steps 0->1 before edge E0 and is held -> clean[0]=1 after E5; press[0]=1 for exactly the cycle after E5. ch1, release and long_press stay 0.
- ch0 bounces 1,0,1,0 with each level held 3 clocks, then stays 1 -> no clean change during the bouncing; clean rises only 5 edges after the final stable level is sampled; exactly one press pulse.
- ch0 held 1 for 20 clocks after press -> long_press[0] pulses once, 8 clocks after press[0], and never again. A second trial releasing after 6 clocks -> no long_press; release[0] pulses once, 5 edges after the 0 is sampled.
- Both channels step to 1 on the same edge -> press=2'b11 in the same cycle. A third trial uses tick asserted 1 clock in 4 -> clean rises after 4 ticks, not 4 clocks.
- rst_n asserted 2 clocks into qualification, then released with input still 1 -> no pulse across reset; qualification restarts from 0 (clean rises 5 edges after reset release plus synchroniser refill).
